arith_op_sequencer: RTL and testbench
=====================================

Name: arith_op_sequencer

Overview:
- Initiator side of the 3-bit arithmetic circuit interface (ops: a-1, a+b, a-b, -b).
- Accepts operation requests over a valid/ready handshake and drives the circuit's select and operand lines from registers.
- Waits a programmable settle time, then captures the result and computes a signed-overflow flag.
- Returns the result over a second valid/ready handshake. Sits between a command source and the combinational arithmetic unit.

Parameters:
- WIDTH, 3, operand/result width in bits (two's complement).
- SETTLE_CYCLES, 1, clock edges between driving the arithmetic unit and sampling alu_g; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  operation: 00 a-1, 01 a+b, 10 a-b, 11 -b (op[1]=s1, op[0]=s0).
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- alu_s0  output  1  select s0 to the arithmetic unit.
- alu_s1  output  1  select s1 to the arithmetic unit.
- alu_a  output  WIDTH  operand A to the arithmetic unit.
- alu_b  output  WIDTH  operand B to the arithmetic unit.
- alu_g  input  WIDTH  result g from the arithmetic unit.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_g  output  WIDTH  captured result.
- rsp_ovf  output  1  signed overflow of the captured operation.
- rsp_err  output  1  self-check mismatch (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): state IDLE, req_ready=1, rsp_valid=0, rsp_g=0, rsp_ovf=0, rsp_err=0, alu_s0=alu_s1=0, alu_a=alu_b=0, settle counter=0.
- FSM states IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, register req_op/req_a/req_b onto alu_s1/alu_s0/alu_a/alu_b.
  - Load the counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - req_ready=0; the alu_* outputs are held stable.
  - Each edge with counter!=0 decrements the counter.
  - On the edge with counter==0: capture alu_g into rsp_g, compute rsp_ovf, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_g, rsp_ovf and rsp_err are held until an edge with rsp_ready=1.
  - On that edge, rsp_valid drops and the state returns to IDLE.
  - req_valid is ignored in RESP (req_ready=0).
- Latency: request accepted at edge T; rsp_valid is high after edge T+SETTLE_CYCLES. Back-to-back throughput is one op per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
- alu_* outputs retain the last operation's values in IDLE and RESP; they change only on request acceptance.
- Overflow (sign bit = bit WIDTH-1; g = captured alu_g; MIN = 1 followed by WIDTH-1 zeros, i.e. 100 for WIDTH=3):
  - op 01: a[msb]==b[msb] and g[msb]!=a[msb].
  - op 10: a[msb]!=b[msb] and g[msb]!=a[msb].
  - op 00: a==MIN.
  - op 11: b==MIN.
- Arithmetic is modulo 2^WIDTH. rsp_g is always the raw alu_g, never saturated.
- Reset asserted mid-operation (SETTLE or RESP) aborts immediately to reset values; no response is produced for the aborted request.
- req_valid deasserting while already in SETTLE has no effect; the captured operation completes.

Optional Feature:
- Macro ARITH_SELFCHECK_EN.
- Defined:
  - An internal behavioural model computes the expected result from the registered op/a/b (a-1, a+b, a+~b+1, ~b+1 modulo 2^WIDTH).
  - rsp_err is set in the capture cycle when alu_g differs from the expected result, and is held with rsp_g.
- Not defined: rsp_err is tied to 0 and no model logic exists.

Test Plan:
- a=110, b=111, op 01, SETTLE_CYCLES=1, rsp_ready=1 -> alu_s1/s0=0/1 one edge after accept; rsp_valid after edge T+1; rsp_g=101, rsp_ovf=0.
- a=101, b=101, op 01 -> rsp_g=010, rsp_ovf=1. Then a=101, b=011, op 10 -> rsp_g=010, rsp_ovf=1.
- Edge cases: a=100, op 00 -> rsp_g=011, rsp_ovf=1. b=100, op 11 -> rsp_g=100, rsp_ovf=1. b=000, op 11 -> rsp_g=000, rsp_ovf=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_g and rsp_ovf stable, req_ready=0. A new req_valid is not accepted until one cycle after rsp_ready=1.
- Reset: rst_n pulsed low mid-SETTLE (SETTLE_CYCLES=4) -> all outputs return to reset values immediately, no rsp_valid, req_ready=1 after release.
- With ARITH_SELFCHECK_EN, the bench model forces alu_g=000 for a=110, b=111, op 10 -> rsp_err=1, rsp_g=000. With the correct alu_g=111 -> rsp_err=0.

Source files
------------

// File: rtl/arith_op_sequencer.sv
// Purpose: initiator for the 3-op arithmetic unit; registers op/operands, waits, captures g and flags signed overflow.
// Latency: accept at edge T, rsp_valid high after edge T+SETTLE_CYCLES; one op per SETTLE_CYCLES+2 cycles back-to-back.
// Backpressure: req_ready is low from accept until the response handshake; response held while rsp_ready=0.
// Optional: define ARITH_SELFCHECK_EN to compare alu_g against an internal model and flag rsp_err.
module arith_op_sequencer #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_g,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_g,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Operation as driven onto the arithmetic unit; s1/s0 order matches req_op bits.
  typedef struct packed {
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] settle_cnt;
  logic             ovf_next;
  logic             err_next;

  assign alu_s1 = op_q.s1;
  assign alu_s0 = op_q.s0;
  assign alu_a  = op_q.a;
  assign alu_b  = op_q.b;

  // Signed overflow of the operation currently on the unit, judged from the sampled result sign.
  always_comb begin
    ovf_next = 1'b0;
    case ({op_q.s1, op_q.s0})
      2'b00:   ovf_next = (op_q.a == MIN_VAL);
      2'b01:   ovf_next = (op_q.a[WIDTH-1] == op_q.b[WIDTH-1]) &&
                          (alu_g[WIDTH-1] != op_q.a[WIDTH-1]);
      2'b10:   ovf_next = (op_q.a[WIDTH-1] != op_q.b[WIDTH-1]) &&
                          (alu_g[WIDTH-1] != op_q.a[WIDTH-1]);
      default: ovf_next = (op_q.b == MIN_VAL);
    endcase
  end

`ifdef ARITH_SELFCHECK_EN
  logic [WIDTH-1:0] exp_g;
  logic             err_q;

  // Reference result for the registered operation; subtraction written as a + ~b + 1 like the hardware.
  always_comb begin
    exp_g = '0;
    case ({op_q.s1, op_q.s0})
      2'b00:   exp_g = op_q.a - WIDTH'(1);
      2'b01:   exp_g = op_q.a + op_q.b;
      2'b10:   exp_g = op_q.a + ~op_q.b + WIDTH'(1);
      default: exp_g = ~op_q.b + WIDTH'(1);
    endcase
    err_next = (alu_g != exp_g);
  end

  assign rsp_err = err_q;
`else
  assign err_next = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // Control FSM: accept, count settle edges, capture the result, hold it until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      settle_cnt <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_g      <= '0;
      rsp_ovf    <= 1'b0;
`ifdef ARITH_SELFCHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q.s1    <= req_op[1];
            op_q.s0    <= req_op[0];
            op_q.a     <= req_a;
            op_q.b     <= req_b;
            settle_cnt <= CNT_INIT;
            req_ready  <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end else begin
            rsp_g     <= alu_g;
            rsp_ovf   <= ovf_next;
            rsp_valid <= 1'b1;
`ifdef ARITH_SELFCHECK_EN
            err_q     <= err_next;
`endif
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Purpose: directed check of arith_op_sequencer at SETTLE_CYCLES=1 and 4 against hand-computed results.
// Latency: checks the exact response latency and the back-to-back handshake timing.
// Backpressure: holds rsp_ready low to verify the response and req_ready are held.
module tb_arith_op_sequencer;

  localparam int W = 3;

`ifdef ARITH_SELFCHECK_EN
  localparam logic SELFCHECK = 1'b1;
`else
  localparam logic SELFCHECK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance with SETTLE_CYCLES=1
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_b, alu_a, alu_b, alu_g, rsp_g;
  logic         alu_s0, alu_s1, rsp_ovf, rsp_err;
  logic         force_zero;

  // Instance with SETTLE_CYCLES=4
  logic         req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [1:0]   req_op4;
  logic [W-1:0] req_a4, req_b4, alu_a4, alu_b4, alu_g4, rsp_g4;
  logic         alu_s04, alu_s14, rsp_ovf4, rsp_err4;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural arithmetic unit the sequencer drives.
  function automatic logic [W-1:0] alu_model(input logic s1, input logic s0,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    case ({s1, s0})
      2'b00:   return a - W'(1);
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return W'(0) - b;
    endcase
  endfunction

  assign alu_g  = force_zero ? '0 : alu_model(alu_s1, alu_s0, alu_a, alu_b);
  assign alu_g4 = alu_model(alu_s14, alu_s04, alu_a4, alu_b4);

  arith_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_a(alu_a), .alu_b(alu_b), .alu_g(alu_g),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_g(rsp_g),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  arith_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op4),
    .req_a(req_a4), .req_b(req_b4),
    .alu_s0(alu_s04), .alu_s1(alu_s14), .alu_a(alu_a4), .alu_b(alu_b4), .alu_g(alu_g4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_g(rsp_g4),
    .rsp_ovf(rsp_ovf4), .rsp_err(rsp_err4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One full transaction on the SETTLE_CYCLES=1 instance with rsp_ready held high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_g,
                        input logic exp_ovf, input logic exp_err);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".sel"},   32'({alu_s1, alu_s0}), 32'(op));
    chk({tag, ".alu_a"}, 32'(alu_a), 32'(a));
    chk({tag, ".alu_b"}, 32'(alu_b), 32'(b));
    chk({tag, ".rdy"},   32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'd1);
    chk({tag, ".g"},   32'(rsp_g), 32'(exp_g));
    chk({tag, ".ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".done_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int  n;
    logic seen;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid4 = 1'b0; req_op4 = '0; req_a4 = '0; req_b4 = '0; rsp_ready4 = 1'b1;
    force_zero = 1'b0;
    #12;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_g",     32'(rsp_g), 32'd0);
    chk("rst.rsp_ovf",   32'(rsp_ovf), 32'd0);
    chk("rst.rsp_err",   32'(rsp_err), 32'd0);
    chk("rst.sel",       32'({alu_s1, alu_s0}), 32'd0);
    chk("rst.alu_ab",    32'({alu_a, alu_b}), 32'd0);
    chk("rst.req_ready4", 32'(req_ready4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: op, a, b, expected g, expected overflow.
    run_op("add_neg",  2'b01, 3'b110, 3'b111, 3'b101, 1'b0, 1'b0);
    run_op("add_ovfn", 2'b01, 3'b101, 3'b101, 3'b010, 1'b1, 1'b0);
    run_op("sub_ovf",  2'b10, 3'b101, 3'b011, 3'b010, 1'b1, 1'b0);
    run_op("dec_min",  2'b00, 3'b100, 3'b000, 3'b011, 1'b1, 1'b0);
    run_op("neg_min",  2'b11, 3'b010, 3'b100, 3'b100, 1'b1, 1'b0);
    run_op("neg_zero", 2'b11, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    run_op("add_ovfp", 2'b01, 3'b011, 3'b001, 3'b100, 1'b1, 1'b0);
    run_op("sub_ok",   2'b10, 3'b010, 3'b001, 3'b001, 1'b0, 1'b0);
    run_op("dec_ok",   2'b00, 3'b001, 3'b111, 3'b000, 1'b0, 1'b0);

    // Faulty unit output: only the self-check build flags it.
    force_zero = 1'b1;
    run_op("chk_bad", 2'b10, 3'b110, 3'b111, 3'b000, 1'b0, SELFCHECK);
    force_zero = 1'b0;
    run_op("chk_ok",  2'b10, 3'b110, 3'b111, 3'b111, 1'b0, 1'b0);

    // Backpressure: response held, a pending request waits for the handshake.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 3'b001; req_b = 3'b001;
    @(posedge clk);
    @(negedge clk);
    req_a = 3'b010; req_b = 3'b010;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bp.lat", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold_vld", 32'(rsp_valid), 32'd1);
      chk("bp.hold_g",   32'(rsp_g), 32'd2);
      chk("bp.hold_ovf", 32'(rsp_ovf), 32'd0);
      chk("bp.hold_rdy", 32'(req_ready), 32'd0);
      chk("bp.hold_a",   32'(alu_a), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.hs_vld", 32'(rsp_valid), 32'd0);
    chk("bp.hs_rdy", 32'(req_ready), 32'd1);
    chk("bp.hs_a",   32'(alu_a), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.acc_a",   32'(alu_a), 32'd2);
    chk("bp.acc_rdy", 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bp.op2_g",   32'(rsp_g), 32'd4);
    chk("bp.op2_ovf", 32'(rsp_ovf), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp.op2_done", 32'(rsp_valid), 32'd0);

    // SETTLE_CYCLES=4: latency and result.
    req_valid4 = 1'b1; req_op4 = 2'b01; req_a4 = 3'b011; req_b4 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    n = 0;
    while (!rsp_valid4 && n < 30) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("s4.lat", 32'(n), 32'd4);
    chk("s4.g",   32'(rsp_g4), 32'd5);
    chk("s4.ovf", 32'(rsp_ovf4), 32'd1);
    chk("s4.err", 32'(rsp_err4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("s4.done", 32'(rsp_valid4), 32'd0);

    // Reset pulse in the middle of SETTLE aborts the request.
    req_valid4 = 1'b1; req_op4 = 2'b11; req_a4 = 3'b001; req_b4 = 3'b001;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    chk("rs.pre_b", 32'(alu_b4), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rs.req_ready", 32'(req_ready4), 32'd1);
    chk("rs.rsp_valid", 32'(rsp_valid4), 32'd0);
    chk("rs.rsp_g",     32'(rsp_g4), 32'd0);
    chk("rs.rsp_ovf",   32'(rsp_ovf4), 32'd0);
    chk("rs.sel",       32'({alu_s14, alu_s04}), 32'd0);
    chk("rs.alu_ab",    32'({alu_a4, alu_b4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid4) seen = 1'b1;
    end
    chk("rs.no_rsp",     32'(seen), 32'd0);
    chk("rs.ready_after", 32'(req_ready4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
